// File: rtl/fir_s2_engine_if.sv
// Memory-master bus between fir_s2_engine and the FIR memory s2 slave.
interface fir_s2_engine_if #(parameter int ADDR_W = 14);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [63:0]       mem_readdata;
    logic [63:0]       mem_writedata;
    logic [7:0]        mem_byteenable;

    modport master (output mem_address, mem_chipselect, mem_clken, mem_write,
                    mem_writedata, mem_byteenable, input mem_readdata);
    modport slave  (input mem_address, mem_chipselect, mem_clken, mem_write,
                    mem_writedata, mem_byteenable, output mem_readdata);
endinterface

// File: rtl/fir_s2_engine.sv
// Word-serial 4-lane Q1.15 FIR engine reading and writing 64-bit words over the s2 port.
// Define FIR_S2_SAT_EN to saturate results to 16 bits; otherwise results wrap.
module fir_s2_engine #(
    parameter int TAPS   = 8,
    parameter int ADDR_W = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_base,
    input  logic [ADDR_W-1:0]  dst_base,
    input  logic [ADDR_W-1:0]  num_words,
    input  logic               coef_load,
    input  logic [2:0]         coef_idx,
    input  logic signed [15:0] coef_data,
    output logic               busy,
    output logic               done,
    fir_s2_engine_if.master    mem
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, CALC, WR, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  src, dst, nwords, idx;
    logic [1:0]         lane;
    logic [3:0][15:0]   rd_word;
    logic [2:0][15:0]   out_word;
    logic signed [15:0] h  [TAPS];
    logic signed [15:0] dl [TAPS];

    logic signed [15:0] dl_nxt [TAPS];
    logic signed [31:0] prod;
    logic signed [34:0] acc;
    logic [15:0]        y;

    // Shift the current lane sample in, then sum h[t]*x[n-t] over the updated line.
    always_comb begin
        dl_nxt[0] = rd_word[lane];
        for (int t = 1; t < TAPS; t++) dl_nxt[t] = dl[t-1];
        acc  = '0;
        prod = '0;
        for (int t = 0; t < TAPS; t++) begin
            prod = h[t] * dl_nxt[t];
            acc  = acc + {{3{prod[31]}}, prod};
        end
`ifdef FIR_S2_SAT_EN
        if ((acc >>> 15) > 35'sd32767)       y = 16'h7FFF;
        else if ((acc >>> 15) < -35'sd32768) y = 16'h8000;
        else                                 y = 16'(acc >>> 15);
`else
        y = 16'(acc >>> 15);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            src      <= '0;
            dst      <= '0;
            nwords   <= '0;
            idx      <= '0;
            lane     <= '0;
            rd_word  <= '0;
            out_word <= '0;
            for (int t = 0; t < TAPS; t++) begin
                h[t]  <= '0;
                dl[t] <= '0;
            end
            mem.mem_address    <= '0;
            mem.mem_chipselect <= 1'b0;
            mem.mem_clken      <= 1'b0;
            mem.mem_write      <= 1'b0;
            mem.mem_writedata  <= '0;
            mem.mem_byteenable <= '0;
        end else begin
            done               <= 1'b0;
            mem.mem_chipselect <= 1'b0;
            mem.mem_clken      <= 1'b0;
            mem.mem_write      <= 1'b0;
            if (coef_load && (state == IDLE || state == DONE) && 32'(coef_idx) < TAPS)
                h[coef_idx] <= coef_data;
            case (state)
                IDLE: if (start) begin
                    src    <= src_base;
                    dst    <= dst_base;
                    nwords <= num_words;
                    idx    <= '0;
                    for (int t = 0; t < TAPS; t++) dl[t] <= '0;
                    if (num_words != '0) begin
                        state              <= RD_REQ;
                        busy               <= 1'b1;
                        mem.mem_address    <= src_base;
                        mem.mem_chipselect <= 1'b1;
                        mem.mem_clken      <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                RD_REQ: state <= RD_CAP;
                RD_CAP: begin
                    rd_word <= mem.mem_readdata;
                    lane    <= '0;
                    state   <= CALC;
                end
                CALC: begin
                    for (int t = 0; t < TAPS; t++) dl[t] <= dl_nxt[t];
                    out_word <= {y, out_word[2:1]};
                    lane     <= lane + 2'd1;
                    if (lane == 2'd3) begin
                        state              <= WR;
                        mem.mem_address    <= dst + idx;
                        mem.mem_writedata  <= {y, out_word};
                        mem.mem_byteenable <= 8'hFF;
                        mem.mem_chipselect <= 1'b1;
                        mem.mem_clken      <= 1'b1;
                        mem.mem_write      <= 1'b1;
                    end
                end
                WR: begin
                    idx <= idx + 1'b1;
                    if (idx + 1'b1 == nwords) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state              <= RD_REQ;
                        mem.mem_address    <= src + idx + 1'b1;
                        mem.mem_chipselect <= 1'b1;
                        mem.mem_clken      <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_s2_engine.sv
// Directed bench for fir_s2_engine with a 1-cycle-latency memory model on the s2 port.
module tb_fir_s2_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] src_base, dst_base, num_words;
    logic        coef_load;
    logic [2:0]  coef_idx;
    logic [15:0] coef_data;
    logic        busy, done;

    fir_s2_engine_if #(.ADDR_W(14)) mif ();

    fir_s2_engine #(.TAPS(8), .ADDR_W(14)) dut (
        .clk(clk), .reset(reset), .start(start), .src_base(src_base),
        .dst_base(dst_base), .num_words(num_words), .coef_load(coef_load),
        .coef_idx(coef_idx), .coef_data(coef_data), .busy(busy), .done(done),
        .mem(mif)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:16383];
    logic [13:0] rd_log [0:63];
    int          rd_n = 0, wr_n = 0, cs_n = 0;
    logic        pl_en = 1'b0;
    logic [13:0] pl_addr;
    logic [63:0] pl_data;

    // Memory model plus bus activity log.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mif.mem_chipselect && mif.mem_clken) begin
            cs_n <= cs_n + 1;
            if (mif.mem_write) begin
                mem[mif.mem_address] <= mif.mem_writedata;
                wr_n <= wr_n + 1;
            end else begin
                mif.mem_readdata     <= mem[mif.mem_address];
                rd_log[rd_n % 64]    <= mif.mem_address;
                rd_n <= rd_n + 1;
            end
        end
    end

    int checks = 0, failures = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic poke(input logic [13:0] a, input logic [63:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic load_coef(input logic [2:0] i, input logic [15:0] v);
        coef_load = 1'b1; coef_idx = i; coef_data = v;
        tick();
        coef_load = 1'b0;
    endtask

    // Issue start and return the cycle in which done is seen (-1 on timeout).
    task automatic run_job(input logic [13:0] s, input logic [13:0] d, input logic [13:0] n,
                           output int cyc, output int busy_cnt);
        src_base = s; dst_base = d; num_words = n; start = 1'b1;
        tick();
        start = 1'b0; coef_load = 1'b0;
        cyc = 1; busy_cnt = 0;
        while (!done && cyc < 300) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        if (!done) cyc = -1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (mif.mem_chipselect !== 1'b0) begin failures++; $display("FAIL rst_cs got %b exp 0", mif.mem_chipselect); end
        checks++; if (mif.mem_clken !== 1'b0) begin failures++; $display("FAIL rst_clken got %b exp 0", mif.mem_clken); end
        checks++; if (mif.mem_write !== 1'b0) begin failures++; $display("FAIL rst_write got %b exp 0", mif.mem_write); end
        checks++; if (mif.mem_address !== 14'h0) begin failures++; $display("FAIL rst_addr got %h exp 0", mif.mem_address); end
        checks++; if (mif.mem_writedata !== 64'h0) begin failures++; $display("FAIL rst_wdata got %h exp 0", mif.mem_writedata); end
        checks++; if (mif.mem_byteenable !== 8'h0) begin failures++; $display("FAIL rst_be got %h exp 0", mif.mem_byteenable); end
        reset = 1'b0;
        tick();
    endtask

    // Coefficient written in the same cycle as start must be in effect.
    task automatic test_basic();
        int cyc, bc, cs0, wr0;
        poke(14'h010, 64'h0000_0000_0000_1000);
        poke(14'h020, 64'hDEAD_BEEF_DEAD_BEEF);
        cs0 = cs_n; wr0 = wr_n;
        coef_load = 1'b1; coef_idx = 3'd0; coef_data = 16'h4000;
        run_job(14'h010, 14'h020, 14'd1, cyc, bc);
        checks++; if (cyc !== 8) begin failures++; $display("FAIL basic_done_cycle got %0d exp 8", cyc); end
        checks++; if (bc !== 7) begin failures++; $display("FAIL basic_busy_cycles got %0d exp 7", bc); end
        checks++; if (mem[14'h020] !== 64'h0000_0000_0000_0800) begin failures++; $display("FAIL basic_word got %h exp 0000000000000800", mem[14'h020]); end
        checks++; if (cs_n - cs0 !== 2) begin failures++; $display("FAIL basic_cs_cycles got %0d exp 2", cs_n - cs0); end
        checks++; if (wr_n - wr0 !== 1) begin failures++; $display("FAIL basic_writes got %0d exp 1", wr_n - wr0); end
        checks++; if (mif.mem_address !== 14'h020) begin failures++; $display("FAIL basic_addr_hold got %h exp 020", mif.mem_address); end
        checks++; if (mif.mem_writedata !== 64'h800) begin failures++; $display("FAIL basic_wdata_hold got %h exp 800", mif.mem_writedata); end
        checks++; if (mif.mem_byteenable !== 8'hFF) begin failures++; $display("FAIL basic_be_hold got %h exp ff", mif.mem_byteenable); end
    endtask

    // Impulse through h[t]=0x100*(t+1); delay line carries across the two words.
    task automatic test_impulse();
        int cyc, bc;
        for (int t = 0; t < 8; t++) load_coef(3'(t), 16'(16'h0100 * (t + 1)));
        poke(14'h100, 64'h0000_0000_0000_7FFF);
        poke(14'h101, 64'h0);
        run_job(14'h100, 14'h200, 14'd2, cyc, bc);
        checks++; if (cyc !== 15) begin failures++; $display("FAIL imp_done_cycle got %0d exp 15", cyc); end
        checks++; if (bc !== 14) begin failures++; $display("FAIL imp_busy_cycles got %0d exp 14", bc); end
        checks++; if (mem[14'h200] !== 64'h03FF_02FF_01FF_00FF) begin failures++; $display("FAIL imp_word0 got %h exp 03ff02ff01ff00ff", mem[14'h200]); end
        checks++; if (mem[14'h201] !== 64'h07FF_06FF_05FF_04FF) begin failures++; $display("FAIL imp_word1 got %h exp 07ff06ff05ff04ff", mem[14'h201]); end
    endtask

    // Overflow handling; start and coef_load while busy are ignored.
    task automatic test_sat();
        int cyc;
        logic [63:0] exp_w;
`ifdef FIR_S2_SAT_EN
        exp_w = 64'h7FFF_7FFF_7FFF_7FFE;
`else
        exp_w = 64'hFFFC_FFFC_FFFC_7FFE;
`endif
        load_coef(3'd0, 16'h7FFF);
        load_coef(3'd1, 16'h7FFF);
        for (int t = 2; t < 8; t++) load_coef(3'(t), 16'h0);
        poke(14'h300, 64'h7FFF_7FFF_7FFF_7FFF);
        src_base = 14'h300; dst_base = 14'h310; num_words = 14'd1; start = 1'b1;
        tick();
        start = 1'b0; cyc = 1;
        while (!done && cyc < 300) begin
            if (cyc == 3 || cyc == 4) begin
                start = 1'b1; num_words = 14'd5;
                coef_load = 1'b1; coef_idx = 3'd0; coef_data = 16'h0000;
            end else begin
                start = 1'b0; coef_load = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0; coef_load = 1'b0;
        if (!done) cyc = -1;
        checks++; if (cyc !== 8) begin failures++; $display("FAIL sat_done_cycle got %0d exp 8", cyc); end
        tick(); tick();
        checks++; if (mem[14'h310] !== exp_w) begin failures++; $display("FAIL sat_word got %h exp %h", mem[14'h310], exp_w); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sat_idle_after got %b exp 0", busy); end
    endtask

    task automatic test_zero_words();
        int cyc, bc, cs0;
        cs0 = cs_n;
        run_job(14'h050, 14'h060, 14'd0, cyc, bc);
        checks++; if (cyc !== 1) begin failures++; $display("FAIL zero_done_cycle got %0d exp 1", cyc); end
        checks++; if (cs_n - cs0 !== 0) begin failures++; $display("FAIL zero_cs_cycles got %0d exp 0", cs_n - cs0); end
        checks++; if (bc !== 0) begin failures++; $display("FAIL zero_busy_cycles got %0d exp 0", bc); end
    endtask

    task automatic test_wrap();
        int cyc, bc, r0;
        poke(14'h3FFF, 64'h1111);
        poke(14'h0000, 64'h2222);
        r0 = rd_n;
        run_job(14'h3FFF, 14'h1000, 14'd2, cyc, bc);
        checks++; if (cyc !== 15) begin failures++; $display("FAIL wrap_done_cycle got %0d exp 15", cyc); end
        checks++; if (rd_n - r0 !== 2) begin failures++; $display("FAIL wrap_reads got %0d exp 2", rd_n - r0); end
        checks++; if (rd_log[r0 % 64] !== 14'h3FFF) begin failures++; $display("FAIL wrap_rd0 got %h exp 3fff", rd_log[r0 % 64]); end
        checks++; if (rd_log[(r0 + 1) % 64] !== 14'h0000) begin failures++; $display("FAIL wrap_rd1 got %h exp 0000", rd_log[(r0 + 1) % 64]); end
    endtask

    // Reset during CALC of word 1 aborts cleanly; the rerun sees h=0 and a clear line.
    task automatic test_reset_mid();
        int cyc, bc, wr0;
        load_coef(3'd0, 16'h4000);
        for (int w = 0; w < 3; w++) begin
            poke(14'(14'h400 + w), 64'h1234_5678_1000_7FFF);
            poke(14'(14'h410 + w), 64'hDEAD_DEAD_DEAD_DEAD);
        end
        wr0 = wr_n;
        src_base = 14'h400; dst_base = 14'h410; num_words = 14'd3; start = 1'b1;
        tick();
        start = 1'b0; cyc = 1;
        while (cyc < 11) begin tick(); cyc++; end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (mif.mem_chipselect !== 1'b0) begin failures++; $display("FAIL mid_cs got %b exp 0", mif.mem_chipselect); end
        tick();
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if (wr_n - wr0 !== 1) begin failures++; $display("FAIL mid_writes got %0d exp 1", wr_n - wr0); end
        checks++; if (mem[14'h411] !== 64'hDEAD_DEAD_DEAD_DEAD) begin failures++; $display("FAIL mid_no_partial got %h exp deaddeaddeaddead", mem[14'h411]); end
        run_job(14'h400, 14'h410, 14'd3, cyc, bc);
        checks++; if (cyc !== 22) begin failures++; $display("FAIL rerun_done_cycle got %0d exp 22", cyc); end
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (mem[14'(14'h410 + w)] !== 64'h0) begin
                failures++; $display("FAIL rerun_word%0d got %h exp 0", w, mem[14'(14'h410 + w)]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; coef_load = 1'b0; coef_idx = '0; coef_data = '0;
        src_base = '0; dst_base = '0; num_words = '0;
        tick();
        test_reset();
        test_basic();
        test_impulse();
        test_sat();
        test_zero_words();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
